// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared types and constants for the instruction-memory boot loader
package boot_pkg;

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CHECK,
    ST_RUN,
    ST_FAIL
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int CSUM_LEN       = 1;
  localparam int DEF_ADDR_WIDTH = 10;

  function automatic int image_bytes(input int n_words);
    return HDR_LEN + 4 * n_words + CSUM_LEN;
  endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian payload bytes into 32-bit words
module word_assembler
  import boot_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_idx;
  logic [23:0] r_lanes;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_idx   <= 2'd0;
      r_lanes <= 24'd0;
    end else if (i_valid) begin
      r_idx <= r_idx + 2'd1;
      case (r_idx)
        2'd0:    r_lanes[7:0]   <= i_byte;
        2'd1:    r_lanes[15:8]  <= i_byte;
        2'd2:    r_lanes[23:16] <= i_byte;
        default: ;
      endcase
    end
  end

  // Lane 3 is taken straight from the input so the word is complete on its own transfer edge.
  assign o_word_done = i_valid && (r_idx == 2'd3);
  assign o_word      = {i_byte, r_lanes};

endmodule

// File: rtl/boot_loader.sv
// rtl/boot_loader.sv - streams a checksummed image into instruction memory and releases the core
module boot_loader
  import boot_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Byte_Valid,
  input  logic [7:0]            Byte_Data,
  output logic                  Byte_Ready,
  output logic                  Im_Write,
  output logic [ADDR_WIDTH-1:0] Im_Addr,
  output logic [31:0]           Im_Data,
  output logic [15:0]           Words_Loaded,
  output logic                  Cpu_Run,
  output logic                  Load_Error
);

  state_t                r_state;
  logic [15:0]           r_count;
  logic [15:0]           r_addr;
  logic [15:0]           r_words;
  logic [7:0]            r_csum;
  logic                  r_ovf;
  logic                  r_ready;
  logic                  r_write;
  logic                  r_run;
  logic                  r_err;
  logic [ADDR_WIDTH-1:0] r_im_addr;
  logic [31:0]           r_im_data;

  logic        w_xfer;
  logic        w_data_xfer;
  logic        w_word_done;
  logic [31:0] w_word;
  logic        w_out_of_range;
  logic        w_last_word;

  assign w_xfer         = Byte_Valid && r_ready;
  assign w_data_xfer    = w_xfer && (r_state == ST_DATA);
  assign w_out_of_range = (r_addr >> ADDR_WIDTH) != 16'd0;
  assign w_last_word    = ({1'b0, r_addr} + 17'd1) == {1'b0, r_count};

  word_assembler u_asm (
    .i_clk       (Clock),
    .i_rst       (Reset),
    .i_valid     (w_data_xfer),
    .i_byte      (Byte_Data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= ST_HDR_LO;
      r_count   <= 16'd0;
      r_addr    <= 16'd0;
      r_words   <= 16'd0;
      r_csum    <= 8'd0;
      r_ovf     <= 1'b0;
      r_ready   <= 1'b1;
      r_write   <= 1'b0;
      r_run     <= 1'b0;
      r_err     <= 1'b0;
      r_im_addr <= '0;
      r_im_data <= 32'd0;
    end else begin
      r_write <= 1'b0;
      case (r_state)
        ST_HDR_LO: if (w_xfer) begin
          r_count[7:0] <= Byte_Data;
          r_state      <= ST_HDR_HI;
        end
        ST_HDR_HI: if (w_xfer) begin
          r_count[15:8] <= Byte_Data;
          r_csum        <= 8'd0;
          r_state       <= ({Byte_Data, r_count[7:0]} == 16'd0) ? ST_CHECK : ST_DATA;
        end
        ST_DATA: if (w_data_xfer) begin
          r_csum <= r_csum ^ Byte_Data;
          if (w_word_done) begin
            // Words beyond capacity are still consumed so the stream stays in sync with the checksum.
            if (w_out_of_range) begin
              r_ovf <= 1'b1;
            end else begin
              r_write   <= 1'b1;
              r_im_addr <= r_addr[ADDR_WIDTH-1:0];
              r_im_data <= w_word;
            end
            r_addr <= r_addr + 16'd1;
            if (r_words != 16'hFFFF) r_words <= r_words + 16'd1;
            if (w_last_word) r_state <= ST_CHECK;
          end
        end
        ST_CHECK: if (w_xfer) begin
          r_ready <= 1'b0;
          if ((Byte_Data == r_csum) && !r_ovf) begin
            r_state <= ST_RUN;
            r_run   <= 1'b1;
          end else begin
            r_state <= ST_FAIL;
            r_err   <= 1'b1;
          end
        end
        ST_RUN, ST_FAIL: ;
        default: r_state <= ST_HDR_LO;
      endcase
    end
  end

  assign Byte_Ready   = r_ready;
  assign Im_Write     = r_write;
  assign Im_Addr      = r_im_addr;
  assign Im_Data      = r_im_data;
  assign Words_Loaded = r_words;
  assign Cpu_Run      = r_run;
  assign Load_Error   = r_err;

endmodule

// File: tb/tb_boot_loader.sv
// tb/tb_boot_loader.sv - directed table-driven bench for boot_loader
module tb_boot_loader;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic [63:0] exp;
  } vec_t;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        b_valid;
  logic [7:0]  b_data;

  logic        rdy0, wr0, run0, er0;
  logic [9:0]  ad0;
  logic [31:0] dt0;
  logic [15:0] wl0;

  logic        rdy1, wr1, run1, er1;
  logic [0:0]  ad1;
  logic [31:0] dt1;
  logic [15:0] wl1;

  int   tests = 0;
  int   fails = 0;
  wr_t  log0[$];
  wr_t  log1[$];
  int   dbl0;
  logic prev0;
  logic [7:0] img[$];
  vec_t vt[12];

  boot_loader #(.ADDR_WIDTH(10)) dut (
    .Clock(Clock), .Reset(Reset), .Byte_Valid(b_valid), .Byte_Data(b_data),
    .Byte_Ready(rdy0), .Im_Write(wr0), .Im_Addr(ad0), .Im_Data(dt0),
    .Words_Loaded(wl0), .Cpu_Run(run0), .Load_Error(er0)
  );

  boot_loader #(.ADDR_WIDTH(1)) dut1 (
    .Clock(Clock), .Reset(Reset), .Byte_Valid(b_valid), .Byte_Data(b_data),
    .Byte_Ready(rdy1), .Im_Write(wr1), .Im_Addr(ad1), .Im_Data(dt1),
    .Words_Loaded(wl1), .Cpu_Run(run1), .Load_Error(er1)
  );

  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] pk(input logic r, input logic w, input logic [9:0] a,
                                     input logic [31:0] d, input logic [15:0] n,
                                     input logic run, input logic err);
    return {2'b00, r, w, a, d, n, run, err};
  endfunction

  function automatic wr_t at(input wr_t q[$], input int i);
    wr_t none;
    none = '{addr: 16'hDEAD, data: 32'hDEADBEEF};
    return (i < q.size()) ? q[i] : none;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    b_valid = v;
    b_data  = d;
    @(posedge Clock);
    #1;
    if (wr0) log0.push_back('{addr: {6'd0, ad0}, data: dt0});
    if (wr0 && prev0) dbl0++;
    prev0 = wr0;
    if (wr1) log1.push_back('{addr: {15'd0, ad1}, data: dt1});
  endtask

  task automatic clear_logs();
    log0.delete();
    log1.delete();
    dbl0  = 0;
    prev0 = 1'b0;
  endtask

  task automatic do_reset();
    b_valid = 1'b0;
    Reset   = 1'b1;
    #2;
    Reset   = 1'b0;
    clear_logs();
  endtask

  task automatic send(input int gap);
    foreach (img[i]) begin
      step(1'b1, img[i]);
      repeat (gap) step(1'b0, 8'hA5);
    end
  endtask

  task automatic load_ok_image();
    img = '{8'h02, 8'h00, 8'h05, 8'h00, 8'h08, 8'h20, 8'h20, 8'h40, 8'h09, 8'h01, 8'h45};
  endtask

  task automatic check_two_word(input string tag);
    check({tag, "_nwr"},  log0.size(), 2);
    check({tag, "_wr0"},  at(log0, 0), {16'd0, 32'h20080005});
    check({tag, "_wr1"},  at(log0, 1), {16'd1, 32'h01094020});
    check({tag, "_fin"},  pk(rdy0, wr0, ad0, dt0, wl0, run0, er0),
          pk(1'b0, 1'b0, 10'd1, 32'h01094020, 16'd2, 1'b1, 1'b0));
  endtask

  initial begin
    b_valid = 1'b0;
    b_data  = 8'h00;
    Reset   = 1'b1;
    clear_logs();

    vt[0]  = '{1'b1, 8'h02, pk(1, 0, 0, 32'h0, 0, 0, 0)};
    vt[1]  = '{1'b1, 8'h00, pk(1, 0, 0, 32'h0, 0, 0, 0)};
    vt[2]  = '{1'b1, 8'h05, pk(1, 0, 0, 32'h0, 0, 0, 0)};
    vt[3]  = '{1'b1, 8'h00, pk(1, 0, 0, 32'h0, 0, 0, 0)};
    vt[4]  = '{1'b1, 8'h08, pk(1, 0, 0, 32'h0, 0, 0, 0)};
    vt[5]  = '{1'b1, 8'h20, pk(1, 1, 0, 32'h20080005, 1, 0, 0)};
    vt[6]  = '{1'b1, 8'h20, pk(1, 0, 0, 32'h20080005, 1, 0, 0)};
    vt[7]  = '{1'b1, 8'h40, pk(1, 0, 0, 32'h20080005, 1, 0, 0)};
    vt[8]  = '{1'b1, 8'h09, pk(1, 0, 0, 32'h20080005, 1, 0, 0)};
    vt[9]  = '{1'b1, 8'h01, pk(1, 1, 1, 32'h01094020, 2, 0, 0)};
    vt[10] = '{1'b1, 8'h45, pk(0, 0, 1, 32'h01094020, 2, 1, 0)};
    vt[11] = '{1'b1, 8'hFF, pk(0, 0, 1, 32'h01094020, 2, 1, 0)};

    #2;
    check("reset_state", pk(rdy0, wr0, ad0, dt0, wl0, run0, er0), pk(1, 0, 0, 32'h0, 0, 0, 0));
    check("reset_state_aw1", {rdy1, wr1, ad1, dt1, wl1, run1, er1}, {1'b1, 1'b0, 1'b0, 32'h0, 16'h0, 1'b0, 1'b0});
    #1;
    Reset = 1'b0;

    // Two-word image, back-to-back, cycle-by-cycle
    foreach (vt[i]) begin
      step(vt[i].v, vt[i].d);
      check($sformatf("vec%0d", i), pk(rdy0, wr0, ad0, dt0, wl0, run0, er0), vt[i].exp);
    end

    // Bad checksum
    do_reset();
    load_ok_image();
    img[10] = 8'h44;
    send(0);
    check("bad_nwr", log0.size(), 2);
    check("bad_wr0", at(log0, 0), {16'd0, 32'h20080005});
    check("bad_wr1", at(log0, 1), {16'd1, 32'h01094020});
    check("bad_flags", {rdy0, run0, er0}, 3'b001);

    // Empty image
    do_reset();
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    check("empty_prerun", {rdy0, run0, er0}, 3'b100);
    step(1'b1, 8'h00);
    check("empty_run", {rdy0, run0, er0}, 3'b010);
    check("empty_nwr", log0.size(), 0);
    check("empty_words", wl0, 16'd0);

    // Gapped stream
    do_reset();
    load_ok_image();
    send(2);
    check("gap_dbl", dbl0, 0);
    check_two_word("gap");

    // Overflow on the ADDR_WIDTH=1 instance
    do_reset();
    img = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
            8'h01, 8'h02, 8'h03, 8'h04, 8'h8C};
    send(0);
    check("ovf_nwr", log1.size(), 2);
    check("ovf_wr0", at(log1, 0), {16'd0, 32'h44332211});
    check("ovf_wr1", at(log1, 1), {16'd1, 32'h88776655});
    check("ovf_words", wl1, 16'd3);
    check("ovf_flags", {rdy1, run1, er1}, 3'b001);
    check("ovf_big_run", {run0, er0, wl0}, {1'b1, 1'b0, 16'd3});

    // Reset in the middle of DATA, then replay
    do_reset();
    load_ok_image();
    for (int i = 0; i < 5; i++) step(1'b1, img[i]);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst_async", pk(rdy0, wr0, ad0, dt0, wl0, run0, er0), pk(1, 0, 0, 32'h0, 0, 0, 0));
    Reset = 1'b0;
    clear_logs();
    send(0);
    check_two_word("replay");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
